mult_wb_fifo: RTL and testbench

MULT_WB_FIFO -- requirements
Module: mult_wb_fifo

---
 rtl/mult_wb_fifo.sv | 99 +++++++++
 tb/tb_mult_wb_fifo.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_wb_fifo.sv
// Writeback buffer for a 1-cycle multiplier. Results are queued in order and
// drained by the writeback stage. Issue is throttled by a credit check that
// counts both stored entries and the single result that may still be in flight.
module mult_wb_fifo #(
  parameter int XLEN          = 32,
  parameter int TRANS_ID_BITS = 3,
  parameter int DEPTH         = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic                      issue_valid_i,
  output logic                      issue_ready_o,
  input  logic                      mult_valid_i,
  input  logic [XLEN-1:0]           mult_result_i,
  input  logic [TRANS_ID_BITS-1:0]  mult_trans_id_i,
  output logic                      wb_valid_o,
  input  logic                      wb_ready_i,
  output logic [XLEN-1:0]           wb_result_o,
  output logic [TRANS_ID_BITS-1:0]  wb_trans_id_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic                      overflow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [XLEN-1:0]          result;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   rptr_q;
  logic [PW-1:0]   wptr_q;
  logic [CW-1:0]   count_q;
  logic            inflight_q;
  logic            overflow_q;

  logic            full;
  logic            pop;
  logic            push;
  logic            drop;

  // Handshake decode and outputs; everything feeding issue_ready_o is registered.
  always_comb begin
    // NOTE: every always_comb output gets a value before any condition so no latch is inferred.
    full          = 1'b0;
    pop           = 1'b0;
    push          = 1'b0;
    drop          = 1'b0;
    full          = (count_q == CW'(DEPTH));
    wb_valid_o    = (count_q != '0);
    pop           = wb_valid_o & wb_ready_i;
    push          = mult_valid_i & (~full | pop);
    drop          = mult_valid_i & full & ~pop;
    issue_ready_o = (count_q + CW'(inflight_q)) < CW'(DEPTH);
    wb_result_o   = mem_q[rptr_q].result;
    wb_trans_id_o = mem_q[rptr_q].trans_id;
    count_o       = count_q;
    overflow_o    = overflow_q;
  end

  // Pointer, occupancy, credit and sticky-overflow state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      rptr_q     <= '0;
      wptr_q     <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      overflow_q <= 1'b0;
    end else if (flush_i) begin
      rptr_q     <= '0;
      wptr_q     <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (drop) overflow_q <= 1'b1;
      inflight_q <= issue_valid_i & issue_ready_o;
    end
  end

  // Result storage; entries are only observed once count says they are valid.
  // NOTE: the storage array is deliberately left without reset; empty slots are never observed.
  always_ff @(posedge clk_i) begin
    if (push && !flush_i) begin
      mem_q[wptr_q] <= '{result: mult_result_i, trans_id: mult_trans_id_i};
    end
  end

endmodule

// File: tb/tb_mult_wb_fifo.sv
// Directed bench for mult_wb_fifo with a queue-based reference model checked
// every cycle, plus literal expectations for the documented scenarios.
module tb_mult_wb_fifo;

  localparam int XLEN  = 32;
  localparam int TIDW  = 3;
  localparam int DEPTH = 4;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             flush_i;
  logic             issue_valid_i;
  logic             issue_ready_o;
  logic             mult_valid_i;
  logic [XLEN-1:0]  mult_result_i;
  logic [TIDW-1:0]  mult_trans_id_i;
  logic             wb_valid_o;
  logic             wb_ready_i;
  logic [XLEN-1:0]  wb_result_o;
  logic [TIDW-1:0]  wb_trans_id_o;
  logic [$clog2(DEPTH):0] count_o;
  logic             overflow_o;

  mult_wb_fifo #(.XLEN(XLEN), .TRANS_ID_BITS(TIDW), .DEPTH(DEPTH)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .flush_i         (flush_i),
    .issue_valid_i   (issue_valid_i),
    .issue_ready_o   (issue_ready_o),
    .mult_valid_i    (mult_valid_i),
    .mult_result_i   (mult_result_i),
    .mult_trans_id_i (mult_trans_id_i),
    .wb_valid_o      (wb_valid_o),
    .wb_ready_i      (wb_ready_i),
    .wb_result_o     (wb_result_o),
    .wb_trans_id_o   (wb_trans_id_o),
    .count_o         (count_o),
    .overflow_o      (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered queue of results plus a credit for the one
  // multiply that may be in flight and a sticky overflow bit.
  typedef struct packed {
    logic [XLEN-1:0] r;
    logic [TIDW-1:0] id;
  } ent_t;

  ent_t q[$];
  int   m_inflight = 0;
  bit   m_ovf      = 1'b0;

  function automatic bit m_ready();
    return (q.size() + m_inflight) < DEPTH;
  endfunction

  always @(posedge clk_i or posedge rst_i) begin
    bit rdy, do_pop, was_full;
    if (rst_i) begin
      q.delete();
      m_inflight = 0;
      m_ovf      = 1'b0;
    end else if (flush_i) begin
      q.delete();
      m_inflight = 0;
    end else begin
      rdy      = m_ready();
      was_full = (q.size() == DEPTH);
      do_pop   = (q.size() != 0) && wb_ready_i;
      if (do_pop) void'(q.pop_front());
      if (mult_valid_i) begin
        if (!was_full || do_pop) q.push_back('{r: mult_result_i, id: mult_trans_id_i});
        else                     m_ovf = 1'b1;
      end
      m_inflight = (issue_valid_i && rdy) ? 1 : 0;
    end
  end

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk_i) begin
    if (cmp_en) begin
      check("wb_valid", 64'(wb_valid_o), 64'(q.size() != 0));
      check("count", 64'(count_o), 64'(q.size()));
      check("issue_ready", 64'(issue_ready_o), 64'(m_ready()));
      check("overflow", 64'(overflow_o), 64'(m_ovf));
      if (q.size() != 0) begin
        check("wb_result", 64'(wb_result_o), 64'(q[0].r));
        check("wb_trans_id", 64'(wb_trans_id_o), 64'(q[0].id));
      end
    end
  end

  task automatic tick();
    @(negedge clk_i);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int accepted;
    int exp_id;
    int res_id;
    bit prev_acc;
    bit acc;

    rst_i           = 1'b0;
    flush_i         = 1'b0;
    issue_valid_i   = 1'b0;
    mult_valid_i    = 1'b0;
    mult_result_i   = '0;
    mult_trans_id_i = '0;
    wb_ready_i      = 1'b0;
    #1 rst_i = 1'b1;
    tick();
    tick();
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_wb_valid", 64'(wb_valid_o), 64'd0);
    check("rst_issue_ready", 64'(issue_ready_o), 64'd1);
    check("rst_overflow", 64'(overflow_o), 64'd0);
    rst_i  = 1'b0;
    cmp_en = 1'b1;
    tick();

    // Single operation: issue, result one cycle later, written back next cycle.
    issue_valid_i = 1'b1;
    tick();
    issue_valid_i   = 1'b0;
    mult_valid_i    = 1'b1;
    mult_result_i   = 32'h0000_1234;
    mult_trans_id_i = 3'd2;
    wb_ready_i      = 1'b1;
    tick();
    mult_valid_i = 1'b0;
    check("single_valid", 64'(wb_valid_o), 64'd1);
    check("single_result", 64'(wb_result_o), 64'h1234);
    check("single_id", 64'(wb_trans_id_o), 64'd2);
    tick();
    check("single_count_after", 64'(count_o), 64'd0);
    check("single_valid_after", 64'(wb_valid_o), 64'd0);
    wb_ready_i = 1'b0;

    // Wrap and ordering: eight pushes with writeback ready toggling 0/1.
    exp_id = 0;
    for (int i = 0; i < 8; i++) begin
      wb_ready_i      = i[0];
      mult_valid_i    = 1'b1;
      mult_result_i   = 32'hA000 + 32'(i);
      mult_trans_id_i = TIDW'(i);
      if (wb_valid_o && wb_ready_i) begin
        check("wrap_order", 64'(wb_trans_id_o), 64'(exp_id));
        exp_id++;
      end
      tick();
    end
    mult_valid_i = 1'b0;
    for (int k = 0; k < 20 && exp_id < 8; k++) begin
      wb_ready_i = 1'b1;
      if (wb_valid_o) begin
        check("wrap_order", 64'(wb_trans_id_o), 64'(exp_id));
        exp_id++;
      end
      tick();
    end
    wb_ready_i = 1'b0;
    check("wrap_pops", 64'(exp_id), 64'd8);
    check("wrap_empty", 64'(count_o), 64'd0);

    // Stall: issue every cycle with writeback blocked; credits run out at four.
    accepted = 0;
    prev_acc = 1'b0;
    res_id   = 0;
    for (int c = 0; c < 6; c++) begin
      mult_valid_i    = prev_acc;
      mult_result_i   = 32'hB000 + 32'(res_id);
      mult_trans_id_i = TIDW'(res_id);
      if (prev_acc) res_id++;
      issue_valid_i = 1'b1;
      acc      = issue_ready_o;
      prev_acc = acc;
      if (acc) accepted++;
      tick();
    end
    issue_valid_i = 1'b0;
    mult_valid_i  = 1'b0;
    check("stall_accepted", 64'(accepted), 64'd4);
    check("stall_count", 64'(count_o), 64'd4);
    check("stall_ready", 64'(issue_ready_o), 64'd0);
    check("stall_overflow", 64'(overflow_o), 64'd0);

    // Forced overflow: full, no pop, extra result must be dropped.
    mult_valid_i    = 1'b1;
    mult_result_i   = 32'hDEAD;
    mult_trans_id_i = 3'd6;
    tick();
    mult_valid_i = 1'b0;
    check("ovf_flag", 64'(overflow_o), 64'd1);
    check("ovf_count", 64'(count_o), 64'd4);
    check("ovf_head_id", 64'(wb_trans_id_o), 64'd0);
    check("ovf_head_result", 64'(wb_result_o), 64'hB000);

    // Full with simultaneous push and pop: occupancy holds, new entry queued last.
    wb_ready_i      = 1'b1;
    mult_valid_i    = 1'b1;
    mult_result_i   = 32'hC005;
    mult_trans_id_i = 3'd5;
    tick();
    mult_valid_i = 1'b0;
    check("fullpp_count", 64'(count_o), 64'd4);
    check("fullpp_head_id", 64'(wb_trans_id_o), 64'd1);
    tick();
    tick();
    tick();
    check("fullpp_new_id", 64'(wb_trans_id_o), 64'd5);
    check("fullpp_new_result", 64'(wb_result_o), 64'hC005);
    check("fullpp_new_count", 64'(count_o), 64'd1);
    tick();
    wb_ready_i = 1'b0;
    check("fullpp_drained", 64'(count_o), 64'd0);

    // Flush with three entries and a multiply in flight.
    for (int i = 1; i <= 3; i++) begin
      mult_valid_i    = 1'b1;
      mult_result_i   = 32'hE000 + 32'(i);
      mult_trans_id_i = TIDW'(i);
      issue_valid_i   = (i == 3);
      tick();
    end
    mult_valid_i = 1'b0;
    check("flush_pre_count", 64'(count_o), 64'd3);
    flush_i = 1'b1;
    tick();
    flush_i       = 1'b0;
    issue_valid_i = 1'b0;
    check("flush_count", 64'(count_o), 64'd0);
    check("flush_wb_valid", 64'(wb_valid_o), 64'd0);
    check("flush_ready", 64'(issue_ready_o), 64'd1);
    check("flush_keeps_overflow", 64'(overflow_o), 64'd1);

    // A result right after the flush is stored normally.
    mult_valid_i    = 1'b1;
    mult_result_i   = 32'h0F0F;
    mult_trans_id_i = 3'd4;
    tick();
    mult_valid_i = 1'b0;
    check("post_flush_count", 64'(count_o), 64'd1);
    check("post_flush_id", 64'(wb_trans_id_o), 64'd4);

    // Asynchronous reset mid-cycle clears state without a clock edge.
    @(posedge clk_i);
    #3 rst_i = 1'b1;
    #1;
    check("async_overflow", 64'(overflow_o), 64'd0);
    check("async_ready", 64'(issue_ready_o), 64'd1);
    check("async_count", 64'(count_o), 64'd0);
    check("async_wb_valid", 64'(wb_valid_o), 64'd0);
    tick();
    tick();
    rst_i = 1'b0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
